// File: rtl/nco_pkg.sv
// Shared NCO constants and helpers: default accumulator width,
// slot-width function and rate-to-increment conversion.
package nco_pkg;

    localparam int NCO_ACC_WIDTH = 20;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // round(2^W * f_out * channels / f_in), shared with the single-channel NCO
    function automatic logic [NCO_ACC_WIDTH-1:0] inc_for(
        input longint f_in,
        input longint f_out,
        input int     channels
    );
        longint num;
        num = (f_out * longint'(channels)) << NCO_ACC_WIDTH;
        return NCO_ACC_WIDTH'((num + f_in / 2) / f_in);
    endfunction

endpackage

// File: rtl/nco_cfg_shadow.sv
// Per-channel configuration shadow: holds staged writes and a pending
// bit per channel, and releases them as a load mask on commit.
module nco_cfg_shadow
    import nco_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int AW = NCO_ACC_WIDTH,
    localparam int SW = clog2(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         commit_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [SW-1:0]                cfg_chan_i,
    input  logic [AW-1:0]                cfg_inc_i,
    input  logic                         cfg_on_i,
    input  logic                         cfg_zero_i,
    output logic [CHANNELS-1:0]          load_o,
    output logic [CHANNELS-1:0][AW-1:0]  sh_inc_o,
    output logic [CHANNELS-1:0]          sh_on_o,
    output logic [CHANNELS-1:0]          sh_zero_o,
    output logic                         frame_o
);

    logic [CHANNELS-1:0]         pend_q, pend_d;
    logic [CHANNELS-1:0]         on_q, on_d;
    logic [CHANNELS-1:0]         zero_q, zero_d;
    logic [CHANNELS-1:0][AW-1:0] inc_q, inc_d;
    logic                        frame_q;
    logic                        accept;

    assign cfg_ready_o = !rst && !pend_q[cfg_chan_i];
    assign accept      = cfg_valid_i && cfg_ready_o;
    assign load_o      = commit_i ? pend_q : '0;

    // An accept only targets a non-pending channel, so it never collides
    // with that channel being released on the same cycle.
    always_comb begin
        pend_d = pend_q & ~load_o;
        inc_d  = inc_q;
        on_d   = on_q;
        zero_d = zero_q;
        if (accept) begin
            pend_d[cfg_chan_i] = 1'b1;
            inc_d[cfg_chan_i]  = cfg_inc_i;
            on_d[cfg_chan_i]   = cfg_on_i;
            zero_d[cfg_chan_i] = cfg_zero_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            inc_q   <= '0;
            on_q    <= '0;
            zero_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            inc_q   <= inc_d;
            on_q    <= on_d;
            zero_q  <= zero_d;
            frame_q <= |load_o;
        end
    end

    assign sh_inc_o  = inc_q;
    assign sh_on_o   = on_q;
    assign sh_zero_o = zero_q;
    assign frame_o   = frame_q;

endmodule

// File: rtl/nco_tdm_sched.sv
// Time-multiplexed NCO: one shared adder services CHANNELS phase
// accumulators round-robin, emitting a one-cycle enable per carry.
module nco_tdm_sched
    import nco_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int ACC_WIDTH = NCO_ACC_WIDTH,
    localparam int SW = clog2(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [SW-1:0]        cfg_chan,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    input  logic                 cfg_on,
    input  logic                 cfg_zero,
    output logic [CHANNELS-1:0]  enable,
    output logic                 frame
);

    logic [SW-1:0]                      slot_q, slot_d;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] inc_q, inc_d;
    logic [CHANNELS-1:0]                on_q, on_d;
    logic [CHANNELS-1:0]                en_q, en_d;

    logic                               commit;
    logic                               service;
    logic [ACC_WIDTH:0]                 sum;
    logic [CHANNELS-1:0]                load;
    logic [CHANNELS-1:0][ACC_WIDTH-1:0] sh_inc;
    logic [CHANNELS-1:0]                sh_on;
    logic [CHANNELS-1:0]                sh_zero;

    assign commit  = run && (slot_q == SW'(CHANNELS - 1));
    assign service = run && on_q[slot_q];
    assign sum     = {1'b0, acc_q[slot_q]} + {1'b0, inc_q[slot_q]};

    nco_cfg_shadow #(
        .CHANNELS (CHANNELS),
        .AW       (ACC_WIDTH)
    ) u_shadow (
        .clk         (clk),
        .rst         (rst),
        .commit_i    (commit),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_chan_i  (cfg_chan),
        .cfg_inc_i   (cfg_inc),
        .cfg_on_i    (cfg_on),
        .cfg_zero_i  (cfg_zero),
        .load_o      (load),
        .sh_inc_o    (sh_inc),
        .sh_on_o     (sh_on),
        .sh_zero_o   (sh_zero),
        .frame_o     (frame)
    );

    // The commit-cycle service uses pre-commit inc/on; a staged clear
    // is applied after it so it overrides that writeback.
    always_comb begin
        slot_d = run ? slot_q + SW'(1) : slot_q;
        acc_d  = acc_q;
        inc_d  = inc_q;
        on_d   = on_q;
        en_d   = '0;
        if (service) begin
            acc_d[slot_q] = sum[ACC_WIDTH-1:0];
            en_d[slot_q]  = sum[ACC_WIDTH];
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (load[c]) begin
                inc_d[c] = sh_inc[c];
                on_d[c]  = sh_on[c];
                if (sh_zero[c]) acc_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            acc_q  <= '0;
            inc_q  <= '0;
            on_q   <= '0;
            en_q   <= '0;
        end else begin
            slot_q <= slot_d;
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            on_q   <= on_d;
            en_q   <= en_d;
        end
    end

    assign enable = en_q;

endmodule

// File: tb/tb_nco_tdm_sched.sv
// Directed bench for nco_tdm_sched: a cycle table of hand-computed
// vectors followed by long-run rate, backpressure and freeze sequences.
module tb_nco_tdm_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_chan = '0;
    logic [19:0] cfg_inc = '0;
    logic        cfg_on = 1'b0;
    logic        cfg_zero = 1'b0;
    logic [3:0]  enable;
    logic        frame;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nco_tdm_sched #(
        .CHANNELS  (4),
        .ACC_WIDTH (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .cfg_on    (cfg_on),
        .cfg_zero  (cfg_zero),
        .enable    (enable),
        .frame     (frame)
    );

    typedef struct {
        logic        rst;
        logic        run;
        logic        vld;
        logic [1:0]  ch;
        logic [19:0] inc;
        logic        on;
        logic        zero;
        logic        rdy;
        logic        frm;
        logic [3:0]  en;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic ru, input logic v,
                       input logic [1:0] c, input logic [19:0] i,
                       input logic o, input logic z, input logic rd,
                       input logic f, input logic [3:0] e);
        vec_t x;
        x.rst = r; x.run = ru; x.vld = v; x.ch = c; x.inc = i;
        x.on = o; x.zero = z; x.rdy = rd; x.frm = f; x.en = e;
        tbl.push_back(x);
    endtask

    task automatic nop(input logic rd, input logic f, input logic [3:0] e);
        add(0, 1, 0, 2'd0, 20'h0, 0, 0, rd, f, e);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) nop(1, 0, 4'h0);
    endtask

    task automatic drive(input logic v, input logic [1:0] c,
                         input logic [19:0] i, input logic o,
                         input logic z);
        cfg_valid = v; cfg_chan = c; cfg_inc = i;
        cfg_on = o; cfg_zero = z;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b1;
        drive(0, 2'd0, 20'h0, 0, 0);
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nf;
        int cnt [4];
        int q[$];
        int fq[$];
        int exp_p [4];

        // ---------------- cycle table ----------------
        add(1, 1, 0, 2'd0, 20'h0, 0, 0, 0, 0, 4'h0);
        add(1, 1, 0, 2'd0, 20'h0, 0, 0, 0, 0, 4'h0);
        add(0, 1, 1, 2'd0, 20'h80000, 1, 1, 1, 0, 4'h0);
        add(0, 1, 1, 2'd0, 20'h40000, 1, 0, 0, 0, 4'h0);
        add(0, 1, 1, 2'd1, 20'hC0000, 1, 0, 1, 0, 4'h0);
        nop(0, 1, 4'h0);
        nops(4);
        nop(1, 0, 4'h1); nop(1, 0, 4'h2); nop(1, 0, 4'h0);
        nop(1, 0, 4'h0); nop(1, 0, 4'h0); nop(1, 0, 4'h2);
        add(0, 0, 0, 2'd0, 20'h0, 0, 0, 1, 0, 4'h0);
        add(0, 0, 0, 2'd0, 20'h0, 0, 0, 1, 0, 4'h0);
        nop(1, 0, 4'h0); nop(1, 0, 4'h0); nop(1, 0, 4'h1);
        nop(1, 0, 4'h2); nop(1, 0, 4'h0);
        add(0, 1, 1, 2'd3, 20'hFFFFF, 1, 0, 1, 0, 4'h0);
        nops(3);
        add(0, 1, 0, 2'd3, 20'h0, 0, 0, 0, 1, 4'h0);
        add(0, 1, 0, 2'd3, 20'h0, 0, 0, 1, 0, 4'h1);
        nop(1, 0, 4'h2); nop(1, 0, 4'h0); nop(1, 0, 4'h0);
        nop(1, 0, 4'h0); nop(1, 0, 4'h2); nop(1, 0, 4'h0);
        nop(1, 0, 4'h8);
        add(0, 1, 1, 2'd0, 20'h00010, 1, 1, 1, 0, 4'h1);
        nop(0, 0, 4'h2);
        nop(0, 0, 4'h0);
        add(1, 1, 0, 2'd0, 20'h0, 0, 0, 0, 0, 4'h0);
        nops(4);
        add(0, 1, 1, 2'd3, 20'h60000, 1, 0, 1, 0, 4'h0);
        nops(2);
        nop(1, 1, 4'h0);
        nops(4);
        add(0, 1, 1, 2'd3, 20'h60000, 1, 1, 1, 0, 4'h0);
        nops(2);
        nop(1, 1, 4'h0);
        nops(11);
        nop(1, 0, 4'h8);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            run = tbl[i].run;
            drive(tbl[i].vld, tbl[i].ch, tbl[i].inc, tbl[i].on, tbl[i].zero);
            #1;
            check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
            tick();
            check($sformatf("tbl%0d_enable", i), 32'(enable), 32'(tbl[i].en));
            check($sformatf("tbl%0d_frame", i), 32'(frame), 32'(tbl[i].frm));
        end

        // ---------------- reset then idle ----------------
        do_reset();
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            cfg_chan = 2'(k);
            #1;
            if (cfg_ready !== 1'b1) bad++;
            tick();
            if (enable !== 4'h0 || frame !== 1'b0) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);

        // ---------------- basic rate ----------------
        do_reset();
        q.delete();
        bad = 0;
        nf = 0;
        for (int k = 0; k < 4096; k++) begin
            if (k == 0) drive(1, 2'd0, 20'h40000, 1, 1);
            else drive(0, 2'd0, 20'h0, 0, 0);
            tick();
            if (enable[0]) q.push_back(k);
            if (enable[3:1] !== 3'b000) bad++;
            if (frame) nf++;
        end
        check("rate_count", 32'(q.size()), 32'd255);
        check("rate_first", 32'(q.size() > 0 ? q[0] : -1), 32'd16);
        for (int i = 1; i < q.size(); i++)
            if (q[i] - q[i-1] != 16) bad++;
        check("rate_spacing_other", 32'(bad), 32'd0);
        check("rate_frames", 32'(nf), 32'd1);

        // ---------------- independent channels ----------------
        do_reset();
        bad = 0;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k < 4100; k++) begin
            case (k)
                0: drive(1, 2'd1, 20'h80000, 1, 1);
                1: drive(1, 2'd2, 20'hFFFFF, 1, 1);
                2: drive(1, 2'd3, 20'h12345, 0, 1);
                default: drive(0, 2'd0, 20'h0, 0, 0);
            endcase
            tick();
            if ($countones(enable) > 1) bad++;
            if (k >= 4)
                for (int c = 0; c < 4; c++) if (enable[c]) cnt[c]++;
        end
        check("indep_ch0", 32'(cnt[0]), 32'd0);
        check("indep_ch1", 32'(cnt[1]), 32'd512);
        check("indep_ch2", 32'(cnt[2]), 32'd1023);
        check("indep_ch3", 32'(cnt[3]), 32'd0);
        check("indep_onehot", 32'(bad), 32'd0);

        // ---------------- backpressure ----------------
        do_reset();
        drive(1, 2'd2, 20'h00001, 1, 0); #1;
        check("bp_first_ch2", 32'(cfg_ready), 32'd1); tick();
        drive(1, 2'd2, 20'h00002, 1, 0); #1;
        check("bp_second_ch2_stall", 32'(cfg_ready), 32'd0); tick();
        drive(1, 2'd1, 20'h00003, 1, 0); #1;
        check("bp_ch1_between", 32'(cfg_ready), 32'd1); tick();
        drive(1, 2'd2, 20'h00002, 1, 0); #1;
        check("bp_ch2_commit_cycle", 32'(cfg_ready), 32'd0); tick();
        check("bp_frame", 32'(frame), 32'd1);
        drive(1, 2'd2, 20'h00002, 1, 0); #1;
        check("bp_ch2_after_commit", 32'(cfg_ready), 32'd1); tick();
        drive(0, 2'd2, 20'h0, 0, 0); #1;
        check("bp_ch2_pending_again", 32'(cfg_ready), 32'd0); tick();

        // ---------------- freeze ----------------
        do_reset();
        q.delete();
        fq.delete();
        bad = 0;
        for (int k = 0; k <= 110; k++) begin
            run = !(k >= 41 && k < 78);
            if (k == 0) drive(1, 2'd0, 20'h40000, 1, 1);
            else if (k == 50) drive(1, 2'd1, 20'h00001, 1, 0);
            else drive(0, 2'd0, 20'h0, 0, 0);
            tick();
            if (enable[0]) q.push_back(k);
            if (enable[3:1] !== 3'b000) bad++;
            if (frame) fq.push_back(k);
            if (!run && (enable !== 4'h0 || frame !== 1'b0)) bad++;
        end
        exp_p = '{16, 32, 85, 101};
        check("frz_npulse", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("frz_pulse%0d", i),
                  32'(i < q.size() ? q[i] : -1), 32'(exp_p[i]));
        check("frz_nframe", 32'(fq.size()), 32'd2);
        check("frz_frame1", 32'(fq.size() > 1 ? fq[1] : -1), 32'd80);
        check("frz_quiet", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
